// File: rtl/mem_stage_if.sv
// Bundles the EX->MEM handshake, the data SRAM port and the MEM->WB handshake of mem_stage.
// No latency of its own; this file contains wiring only.
// Backpressure runs on mem_allowin towards EX and wb_allowin from WB.
interface mem_stage_if;
    // EX -> MEM
    logic        ex_to_mem_valid;
    logic        mem_allowin;
    logic [31:0] ex_pc;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_re;
    logic        ex_mem_we;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_unsigned;
    logic        ex_rf_we;
    logic [4:0]  ex_dest;

    // data SRAM
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    // MEM -> WB
    logic        mem_to_wb_valid;
    logic        wb_allowin;
    logic [31:0] mem_pc;
    logic        mem_rf_we;
    logic [4:0]  mem_dest;
    logic [31:0] mem_result;
    logic        mem_addr_err;

    // The memory stage itself.
    modport slave (
        input  ex_to_mem_valid, ex_pc, ex_result, ex_store_data, ex_mem_re, ex_mem_we,
               ex_mem_size, ex_mem_unsigned, ex_rf_we, ex_dest,
               data_sram_rdata, wb_allowin,
        output mem_allowin, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
               mem_to_wb_valid, mem_pc, mem_rf_we, mem_dest, mem_result, mem_addr_err
    );

    // The surrounding pipeline: EX, WB and the SRAM model.
    modport master (
        output ex_to_mem_valid, ex_pc, ex_result, ex_store_data, ex_mem_re, ex_mem_we,
               ex_mem_size, ex_mem_unsigned, ex_rf_we, ex_dest,
               data_sram_rdata, wb_allowin,
        input  mem_allowin, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
               mem_to_wb_valid, mem_pc, mem_rf_we, mem_dest, mem_result, mem_addr_err
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS32 memory stage: issues data SRAM accesses, aligns/extends loads, hands results to WB.
// Latency: 1 cycle EX->WB; the SRAM request is issued combinationally in the accept cycle.
// Backpressure: mem_allowin = !mem_valid | wb_allowin; load data is buffered while WB stalls.
// Optional feature macro MEM_UNALIGN_EXC_EN: flags misaligned half/word accesses and blocks them.
module mem_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave bus
);
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;

    logic        mem_valid;
    logic        allowin;
    logic        accept;
    logic        is_mem_op;
    logic        misaligned;
    logic [1:0]  ex_a;

    logic [31:0] pc_q;
    logic [31:0] result_q;
    logic [1:0]  size_q;
    logic [1:0]  addr_lo_q;
    logic        unsigned_q;
    logic        re_q;
    logic        rf_we_q;
    logic [4:0]  dest_q;
    logic        err_q;

    logic        buf_valid;
    logic [31:0] rdata_buf;

    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_wdata;

    logic [31:0] load_raw;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;

    // The stage never needs more than one cycle, so it frees up whenever WB takes its result.
    assign allowin   = !mem_valid | bus.wb_allowin;
    assign accept    = bus.ex_to_mem_valid & allowin;
    assign is_mem_op = bus.ex_mem_re | bus.ex_mem_we;
    assign ex_a      = bus.ex_result[1:0];

`ifdef MEM_UNALIGN_EXC_EN
    // Misaligned means the address is not a multiple of the access size.
    always_comb begin
        misaligned = 1'b0;
        case (bus.ex_mem_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = ex_a[0];
            default: misaligned = |ex_a;
        endcase
    end
`else
    // Without the exception path, half/word accesses simply ignore low address bits.
    assign misaligned = 1'b0;
`endif

    // Build the SRAM request: lane-replicated store data plus byte enables.
    always_comb begin
        sram_en    = accept & is_mem_op & !misaligned;
        sram_wen   = 4'b0000;
        sram_wdata = bus.ex_store_data;
        case (bus.ex_mem_size)
            SZ_BYTE: begin
                sram_wdata = {4{bus.ex_store_data[7:0]}};
                sram_wen   = 4'b0001 << ex_a;
            end
            SZ_HALF: begin
                sram_wdata = {2{bus.ex_store_data[15:0]}};
                sram_wen   = ex_a[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                sram_wdata = bus.ex_store_data;
                sram_wen   = 4'b1111;
            end
        endcase
        // Loads and suppressed accesses must never write.
        if (!(sram_en & bus.ex_mem_we)) begin
            sram_wen = 4'b0000;
        end
    end

    assign bus.data_sram_en    = sram_en;
    assign bus.data_sram_wen   = sram_wen;
    assign bus.data_sram_addr  = {bus.ex_result[31:2], 2'b00};
    assign bus.data_sram_wdata = sram_wdata;

    // Stage occupancy: refills (or empties) whenever the stage can take a new instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
        end else if (allowin) begin
            mem_valid <= bus.ex_to_mem_valid;
        end
    end

    // Pipeline registers capture the instruction only when it is actually accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            result_q   <= 32'd0;
            size_q     <= 2'd0;
            addr_lo_q  <= 2'd0;
            unsigned_q <= 1'b0;
            re_q       <= 1'b0;
            rf_we_q    <= 1'b0;
            dest_q     <= 5'd0;
            err_q      <= 1'b0;
        end else if (accept) begin
            pc_q       <= bus.ex_pc;
            result_q   <= bus.ex_result;
            size_q     <= bus.ex_mem_size;
            addr_lo_q  <= ex_a;
            unsigned_q <= bus.ex_mem_unsigned;
            re_q       <= bus.ex_mem_re;
            rf_we_q    <= bus.ex_rf_we;
            dest_q     <= bus.ex_dest;
            // Only real memory accesses can raise an address error.
            err_q      <= misaligned & is_mem_op;
        end
    end

    // SRAM data is only valid in the load's first cycle here; hold it while WB stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            rdata_buf <= 32'd0;
        end else if (allowin) begin
            // Either a new instruction arrives or the stage drains: the buffer is stale.
            buf_valid <= 1'b0;
        end else if (mem_valid & !buf_valid & !bus.wb_allowin) begin
            buf_valid <= 1'b1;
            rdata_buf <= bus.data_sram_rdata;
        end
    end

    assign load_raw = buf_valid ? rdata_buf : bus.data_sram_rdata;

    // Pick the addressed lane(s) and sign/zero-extend to 32 bits.
    always_comb begin
        load_byte = load_raw[7:0];
        case (addr_lo_q)
            2'd0: load_byte = load_raw[7:0];
            2'd1: load_byte = load_raw[15:8];
            2'd2: load_byte = load_raw[23:16];
            2'd3: load_byte = load_raw[31:24];
            default: load_byte = load_raw[7:0];
        endcase
        load_half = addr_lo_q[1] ? load_raw[31:16] : load_raw[15:0];
        case (size_q)
            SZ_BYTE: load_val = {{24{!unsigned_q & load_byte[7]}}, load_byte};
            SZ_HALF: load_val = {{16{!unsigned_q & load_half[15]}}, load_half};
            default: load_val = load_raw;
        endcase
    end

    assign bus.mem_allowin     = allowin;
    assign bus.mem_to_wb_valid = mem_valid;
    assign bus.mem_pc          = pc_q;
    assign bus.mem_dest        = dest_q;
    assign bus.mem_result      = re_q ? load_val : result_q;
    // A faulting access must not update the register file.
    assign bus.mem_rf_we       = rf_we_q & !err_q;
    assign bus.mem_addr_err    = mem_valid & err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors, a transaction-level model and literal checks.
// Model tracks which instruction occupies the stage and the SRAM word seen in its first cycle.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_mem_stage;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_if bus();

    mem_stage #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          chk_en = 0;
    bit          m_valid = 0;
    bit          m_fresh = 0;
    bit          m_re = 0;
    bit          m_uns = 0;
    bit          m_rfwe = 0;
    bit          m_err = 0;
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_res = 32'd0;
    logic [31:0] m_data = 32'd0;
    logic [1:0]  m_size = 2'd0;
    logic [4:0]  m_dest = 5'd0;

    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    // First byte lane touched: address rounded down to the access size.
    function automatic int lane_base(input logic [1:0] sz, input logic [1:0] a);
        int n = nbytes(sz);
        return (int'(a) / n) * n;
    endfunction

    function automatic bit model_mis(input logic [1:0] sz, input logic [1:0] a);
`ifdef MEM_UNALIGN_EXC_EN
        return (int'(a) % nbytes(sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] raw, input logic [1:0] sz,
                                            input logic [1:0] a, input bit uns);
        int n = nbytes(sz);
        logic [31:0] v;
        v = raw >> (8 * lane_base(sz, a));
        if (n == 4) return v;
        if (n == 2) return uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        return uns ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    endfunction

    // Model state advance on the rising edge.
    always @(posedge clk) begin
        if (reset) begin
            m_valid = 0; m_fresh = 0; m_re = 0; m_uns = 0; m_rfwe = 0; m_err = 0;
            m_pc = RESET_PC; m_res = 0; m_size = 0; m_dest = 0;
        end else if (!m_valid || bus.wb_allowin) begin
            m_valid = bus.ex_to_mem_valid;
            if (bus.ex_to_mem_valid) begin
                m_fresh = 1;
                m_pc    = bus.ex_pc;
                m_res   = bus.ex_result;
                m_re    = bus.ex_mem_re;
                m_uns   = bus.ex_mem_unsigned;
                m_rfwe  = bus.ex_rf_we;
                m_size  = bus.ex_mem_size;
                m_dest  = bus.ex_dest;
                m_err   = model_mis(bus.ex_mem_size, bus.ex_result[1:0]) &&
                          (bus.ex_mem_re || bus.ex_mem_we);
            end
        end
        chk_en = 1;
    end

    // Compare all outputs against the model every cycle.
    always @(negedge clk) begin
        bit alw, acc, mem_op, en;
        int base, n;
        logic [3:0]  exp_wen;
        logic [31:0] mask, exp_wd;
        if (chk_en) begin
            if (m_valid && m_fresh) begin
                m_data  = bus.data_sram_rdata;
                m_fresh = 0;
            end
            alw    = !m_valid || bus.wb_allowin;
            acc    = bus.ex_to_mem_valid && alw;
            mem_op = bus.ex_mem_re || bus.ex_mem_we;
            en     = acc && mem_op && !model_mis(bus.ex_mem_size, bus.ex_result[1:0]);
            check("allowin", bus.mem_allowin, alw);
            check("to_wb_valid", bus.mem_to_wb_valid, m_valid);
            check("sram_en", bus.data_sram_en, en);
            check("mem_pc", bus.mem_pc, m_pc);
            check("mem_dest", bus.mem_dest, m_dest);
            check("mem_rf_we", bus.mem_rf_we, m_rfwe && !m_err);
            check("addr_err", bus.mem_addr_err, m_valid && m_err);
            if (m_valid || !m_re)
                check("mem_result", bus.mem_result,
                      m_re ? extract(m_data, m_size, m_res[1:0], m_uns) : m_res);
            if (en) begin
                check("sram_addr", bus.data_sram_addr, bus.ex_result & 32'hFFFF_FFFC);
                n    = nbytes(bus.ex_mem_size);
                base = lane_base(bus.ex_mem_size, bus.ex_result[1:0]);
                exp_wen = 4'b0000;
                mask    = 32'd0;
                exp_wd  = 32'd0;
                for (int i = 0; i < 4; i++) begin
                    if (bus.ex_mem_we && i >= base && i < base + n) begin
                        exp_wen[i] = 1'b1;
                        mask   = mask | (32'hFF << (8 * i));
                        exp_wd = exp_wd | (((bus.ex_store_data >> (8 * (i - base))) & 32'hFF) << (8 * i));
                    end
                end
                check("sram_wen", bus.data_sram_wen, exp_wen);
                if (bus.ex_mem_we) check("sram_wdata", bus.data_sram_wdata & mask, exp_wd);
            end else begin
                check("sram_wen_idle", bus.data_sram_wen, 4'b0000);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit re, input bit we, input logic [1:0] sz,
                         input bit uns, input bit rfwe, input logic [4:0] dest,
                         input logic [31:0] pc, input logic [31:0] res, input logic [31:0] sd);
        bus.ex_to_mem_valid = v;
        bus.ex_mem_re       = re;
        bus.ex_mem_we       = we;
        bus.ex_mem_size     = sz;
        bus.ex_mem_unsigned = uns;
        bus.ex_rf_we        = rfwe;
        bus.ex_dest         = dest;
        bus.ex_pc           = pc;
        bus.ex_result       = res;
        bus.ex_store_data   = sd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 2'd2, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        bus.wb_allowin = 1'b1;
        bus.data_sram_rdata = 32'd0;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bus.mem_to_wb_valid, 32'd0);
        check("rst_allowin", bus.mem_allowin, 32'd1);
        check("rst_en", bus.data_sram_en, 32'd0);
        check("rst_pc", bus.mem_pc, 32'hbfc00000);
        check("rst_result", bus.mem_result, 32'd0);
        check("rst_rf_we", bus.mem_rf_we, 32'd0);
        next_cycle();
        reset = 1'b0;

        // SB at 0x1003
        next_cycle(); drive(1, 0, 1, 2'd0, 0, 0, 5'd0, 32'h100, 32'h1003, 32'h000000AB);
        @(negedge clk);
        check("sb_en", bus.data_sram_en, 32'd1);
        check("sb_wen", bus.data_sram_wen, 32'h8);
        check("sb_addr", bus.data_sram_addr, 32'h1000);
        check("sb_wdata", bus.data_sram_wdata, 32'hABABABAB);
        next_cycle(); idle();
        @(negedge clk);
        check("sb_en_after", bus.data_sram_en, 32'd0);

        // SH at 0x1002, SW at 0x1000
        next_cycle(); drive(1, 0, 1, 2'd1, 0, 0, 5'd0, 32'h104, 32'h1002, 32'h00001234);
        @(negedge clk);
        check("sh_wen", bus.data_sram_wen, 32'hC);
        check("sh_wdata", bus.data_sram_wdata, 32'h12341234);
        next_cycle(); drive(1, 0, 1, 2'd2, 0, 0, 5'd0, 32'h108, 32'h1000, 32'hCAFEF00D);
        @(negedge clk);
        check("sw_wen", bus.data_sram_wen, 32'hF);

        // LB then LBU from 0x1001
        next_cycle(); drive(1, 1, 0, 2'd0, 0, 1, 5'd3, 32'h110, 32'h1001, 32'h0);
        next_cycle(); drive(1, 1, 0, 2'd0, 1, 1, 5'd4, 32'h114, 32'h1001, 32'h0);
        bus.data_sram_rdata = 32'h00008000;
        @(negedge clk);
        check("lb_result", bus.mem_result, 32'hFFFFFF80);
        next_cycle(); idle();
        @(negedge clk);
        check("lbu_result", bus.mem_result, 32'h00000080);
        check("lbu_dest", bus.mem_dest, 32'd4);

        // LW 0x2000 with WB stalled for 3 cycles; a second LW waits in EX
        next_cycle(); drive(1, 1, 0, 2'd2, 0, 1, 5'd5, 32'h120, 32'h2000, 32'h0);
        next_cycle(); drive(1, 1, 0, 2'd2, 0, 1, 5'd6, 32'h124, 32'h2004, 32'h0);
        bus.data_sram_rdata = 32'hDEADBEEF;
        bus.wb_allowin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                next_cycle();
                bus.data_sram_rdata = 32'h0;
            end
            @(negedge clk);
            check("lw_hold_result", bus.mem_result, 32'hDEADBEEF);
            check("lw_hold_allowin", bus.mem_allowin, 32'd0);
            check("lw_hold_en", bus.data_sram_en, 32'd0);
        end
        next_cycle();
        bus.wb_allowin = 1'b1;
        @(negedge clk);
        check("lw_release_result", bus.mem_result, 32'hDEADBEEF);
        check("lw_release_en", bus.data_sram_en, 32'd1);
        check("lw_release_addr", bus.data_sram_addr, 32'h2004);
        next_cycle(); idle();
        bus.data_sram_rdata = 32'h11112222;
        @(negedge clk);
        check("lw2_result", bus.mem_result, 32'h11112222);
        check("lw2_dest", bus.mem_dest, 32'd6);

        // Four back-to-back ALU ops
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(1, 0, 0, 2'd2, 0, 1, 5'(10 + i), 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 32'h0);
            if (i > 0) begin
                @(negedge clk);
                check("alu_dest", bus.mem_dest, 32'(10 + i - 1));
                check("alu_pc", bus.mem_pc, 32'h200 + 32'(4 * (i - 1)));
                check("alu_result", bus.mem_result, 32'hA0 + 32'(i - 1));
            end
        end
        next_cycle(); idle();
        @(negedge clk);
        check("alu_last_dest", bus.mem_dest, 32'd13);
        check("alu_last_result", bus.mem_result, 32'hA3);

        // LH at 0x3001
        next_cycle(); drive(1, 1, 0, 2'd1, 0, 1, 5'd7, 32'h300, 32'h3001, 32'h0);
        @(negedge clk);
`ifdef MEM_UNALIGN_EXC_EN
        check("lh_mis_en", bus.data_sram_en, 32'd0);
`else
        check("lh_en", bus.data_sram_en, 32'd1);
`endif
        next_cycle(); idle();
        bus.data_sram_rdata = 32'h12348765;
        @(negedge clk);
`ifdef MEM_UNALIGN_EXC_EN
        check("lh_mis_err", bus.mem_addr_err, 32'd1);
        check("lh_mis_rf_we", bus.mem_rf_we, 32'd0);
`else
        check("lh_result", bus.mem_result, 32'hFFFF8765);
        check("lh_rf_we", bus.mem_rf_we, 32'd1);
        check("lh_err", bus.mem_addr_err, 32'd0);
`endif

        // LHU at 0x3002 (aligned in both builds)
        next_cycle(); drive(1, 1, 0, 2'd1, 1, 1, 5'd2, 32'h304, 32'h3002, 32'h0);
        next_cycle(); idle();
        bus.data_sram_rdata = 32'hF234_8765;
        @(negedge clk);
        check("lhu_result", bus.mem_result, 32'h0000F234);

        // Reset in the middle of a stalled load
        next_cycle(); drive(1, 1, 0, 2'd2, 0, 1, 5'd8, 32'h400, 32'h4000, 32'h0);
        next_cycle(); idle();
        bus.wb_allowin = 1'b0;
        bus.data_sram_rdata = 32'h55555555;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        bus.wb_allowin = 1'b1;
        @(negedge clk);
        check("midrst_valid", bus.mem_to_wb_valid, 32'd0);
        check("midrst_pc", bus.mem_pc, 32'hbfc00000);
        check("midrst_allowin", bus.mem_allowin, 32'd1);
        next_cycle(); drive(1, 0, 0, 2'd2, 0, 1, 5'd9, 32'h500, 32'h77, 32'h0);
        next_cycle(); idle();
        @(negedge clk);
        check("post_rst_result", bus.mem_result, 32'h77);
        check("post_rst_valid", bus.mem_to_wb_valid, 32'd1);

        repeat (3) next_cycle();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS32 pipeline, between EX and WB.
- Takes the EX result (ALU value or effective address) through a valid/allowin handshake and drives the synchronous data SRAM for loads and stores.
- Aligns and extends load data and presents the write-back result to WB through the same handshake.
- Buffers the SRAM read data so a stalled WB never loses a load.

Parameters:
- RESET_PC, 32'hbfc00000, value held in the pipeline PC register after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_to_mem_valid  in  1  EX holds a valid instruction
- mem_allowin  out  1  this stage accepts an instruction this cycle
- ex_pc  in  32  instruction PC
- ex_result  in  32  ALU result / effective address
- ex_store_data  in  32  rt value for stores
- ex_mem_re  in  1  instruction is a load
- ex_mem_we  in  1  instruction is a store
- ex_mem_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- ex_mem_unsigned  in  1  zero-extend loads (LBU/LHU)
- ex_rf_we  in  1  instruction writes the register file
- ex_dest  in  5  destination register
- data_sram_en  out  1  SRAM access strobe
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  word-aligned address
- data_sram_wdata  out  32  lane-replicated store data
- data_sram_rdata  in  32  read data, one cycle after the access
- mem_to_wb_valid  out  1  a valid result is offered to WB
- wb_allowin  in  1  WB accepts this cycle
- mem_pc  out  32  PC of the instruction in this stage
- mem_rf_we  out  1  register write enable forwarded to WB
- mem_dest  out  5  destination register forwarded to WB
- mem_result  out  32  write-back value
- mem_addr_err  out  1  misaligned access flag (only with the optional feature)

Behaviour:
- Handshake:
  - mem_allowin = !mem_valid | wb_allowin; readygo is always 1.
  - mem_to_wb_valid = mem_valid.
  - Accept when ex_to_mem_valid & mem_allowin. The pipeline registers (pc, result, size, unsigned, re, rf_we, dest, address low bits) load only on accept.
  - mem_valid <= ex_to_mem_valid whenever mem_allowin.
- Reset:
  - mem_valid = 0, buf_valid = 0, all pipeline registers = 0, PC register = RESET_PC.
  - Outputs after reset: mem_to_wb_valid = 0, mem_rf_we = 0, mem_dest = 0, mem_result = 0, mem_addr_err = 0, mem_pc = RESET_PC.
  - Reset asserted mid-access discards the pending load and buffer. SRAM outputs are combinational and are suppressed by accept gating only.
- SRAM request (combinational, issued in the accept cycle):
  - data_sram_en = accept & (ex_mem_re | ex_mem_we) & !misaligned.
  - data_sram_addr = {ex_result[31:2], 2'b00}.
  - Store: byte → wdata = {4{d[7:0]}}, wen = 4'b0001 << a[1:0]. Half → wdata = {2{d[15:0]}}, wen = a[1] ? 4'b1100 : 4'b0011. Word → wdata = d, wen = 4'b1111.
  - wen = 0 for loads and whenever data_sram_en = 0.
- Load return:
  - rdata is valid in the first cycle the load sits in the stage.
  - If mem_valid & !buf_valid & !wb_allowin, capture rdata into rdata_buf and set buf_valid.
  - Clear buf_valid on any accept or when the stage empties.
  - Raw load data = buf_valid ? rdata_buf : data_sram_rdata.
- Load extraction, with a = registered address bits [1:0]:
  - Byte: select bits [8a+7:8a], then sign- or zero-extend.
  - Half: a[1] selects bits [31:16] or [15:0], then extend.
  - Word: pass through unchanged.
- Result select: mem_result = registered re ? extracted load : registered ex_result.
- Simultaneous events:
  - Accept and WB consume in the same cycle is a normal single-cycle pass-through.
  - Back-to-back loads are fully pipelined, one per cycle.
- Latency: 1 cycle EX→WB when WB never stalls.

Optional Feature:
- Macro MEM_UNALIGN_EXC_EN.
- Defined:
  - misaligned = (half & a[0]) | (word & a[1:0] != 0).
  - On a misaligned access, data_sram_en = 0 and wen = 0.
  - The registered flag drives mem_addr_err = mem_valid & flag, and mem_rf_we is forced to 0.
- Undefined:
  - misaligned is tied to 0 and mem_addr_err is tied to 0.
  - Half accesses ignore a[0]; word accesses ignore a[1:0].

Test Plan:
- Reset 3 cycles → mem_to_wb_valid = 0, mem_allowin = 1, data_sram_en = 0, mem_pc = 32'hbfc00000.
- SB, ex_result = 32'h1003, store_data = 32'h000000AB → wen = 4'b1000, addr = 32'h1000, wdata = 32'hABABABAB, en = 1 only in the accept cycle.
- LB then LBU from 32'h1001 with rdata = 32'h00008000 → mem_result = 32'hFFFFFF80, then 32'h00000080.
- LW 32'h2000 returning 32'hDEADBEEF with wb_allowin held 0 for 3 cycles, while rdata changes to 32'h0 → mem_result stays 32'hDEADBEEF, mem_allowin = 0, and no new SRAM access occurs until release.
- Four back-to-back ALU ops with wb_allowin = 1 → one result per cycle, each with 1-cycle latency and correct dest/PC order.
- With MEM_UNALIGN_EXC_EN, LH at 32'h3001 → data_sram_en = 0, mem_addr_err = 1, mem_rf_we = 0. Without the macro, the same load reads lanes [15:0].
